// File: rtl/arch_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arch_defs_pkg
//  Purpose  : Shared definitions for the UART MMIO controller: bus width,
//             register addresses, STATUS/CONTROL/COMMAND bit indices and the
//             TX sequencer state type.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package arch_defs_pkg;

   localparam int DATA_WIDTH = 8;

   // Register select values on cpu_addr
   localparam logic [1:0] UART_REG_DATA    = 2'd0;
   localparam logic [1:0] UART_REG_STATUS  = 2'd1;
   localparam logic [1:0] UART_REG_CONTROL = 2'd2;
   localparam logic [1:0] UART_REG_COMMAND = 2'd3;

   // STATUS bit positions
   localparam int UART_STAT_TX_EMPTY  = 0;
   localparam int UART_STAT_RX_FULL   = 1;
   localparam int UART_STAT_FRAME_ERR = 2;
   localparam int UART_STAT_RX_OVR    = 3;
   localparam int UART_STAT_TX_OVR    = 4;

   // CONTROL bit positions
   localparam int UART_CTRL_RX_IRQ_EN = 0;
   localparam int UART_CTRL_TX_IRQ_EN = 1;

   // COMMAND bit positions
   localparam int UART_CMD_CLR_ERR = 0;
   localparam int UART_CMD_FLUSH   = 1;

   typedef enum logic [1:0] {
      TX_SEQ_IDLE      = 2'd0,
      TX_SEQ_START     = 2'd1,
      TX_SEQ_WAIT_BUSY = 2'd2,
      TX_SEQ_WAIT_DONE = 2'd3
   } uart_tx_seq_state_t;

endpackage : arch_defs_pkg
`default_nettype wire

// File: rtl/uart_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_sequencer
//  Purpose  : Single-entry TX holding register plus the FSM that launches the
//             held byte into the transmitter and follows its busy handshake.
//  Ports    : clk, reset          - clock, async active-high reset
//             wr_en, wr_data      - CPU write to the DATA register
//             flush               - empties the holding register
//             tx_strobe_busy      - transmitter busy level
//             tx_hold_full        - holding register occupied
//             wr_drop             - write rejected this cycle (holding full)
//             fsm_idle            - sequencer in IDLE
//             tx_parallel_data_in - launched byte (held until next launch)
//             tx_strobe_start     - one-cycle start pulse (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sequencer
   import arch_defs_pkg::*;
#(
   parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  flush,
   input  logic                  tx_strobe_busy,
   output logic                  tx_hold_full,
   output logic                  wr_drop,
   output logic                  fsm_idle,
   output logic [DATA_WIDTH-1:0] tx_parallel_data_in,
   output logic                  tx_strobe_start
);

   uart_tx_seq_state_t    r_state;
   logic [DATA_WIDTH-1:0] r_hold;
   logic                  r_hold_full;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_start;

   // A write is only accepted into an empty holding register.
   assign wr_drop             = wr_en & r_hold_full;
   assign tx_hold_full        = r_hold_full;
   assign fsm_idle            = (r_state == TX_SEQ_IDLE);
   assign tx_parallel_data_in = r_tx_data;
   assign tx_strobe_start     = r_start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= TX_SEQ_IDLE;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_tx_data   <= '0;
         r_start     <= 1'b0;
      end else begin
         // Holding register: an accepted write outranks flush and the
         // release performed by START.
         if (wr_en && !r_hold_full) begin
            r_hold      <= wr_data;
            r_hold_full <= 1'b1;
         end else if (flush || (r_state == TX_SEQ_START)) begin
            r_hold_full <= 1'b0;
         end

         r_start <= 1'b0;

         case (r_state)
            TX_SEQ_IDLE: begin
               if (r_hold_full) begin
                  // Start pulse and launched byte are registered on entry
                  // so both are valid exactly during the START cycle.
                  r_state   <= TX_SEQ_START;
                  r_start   <= 1'b1;
                  r_tx_data <= r_hold;
               end
            end
            TX_SEQ_START: begin
               r_state <= TX_SEQ_WAIT_BUSY;
            end
            TX_SEQ_WAIT_BUSY: begin
               if (tx_strobe_busy) begin
                  r_state <= TX_SEQ_WAIT_DONE;
               end
            end
            TX_SEQ_WAIT_DONE: begin
               if (!tx_strobe_busy) begin
                  r_state <= TX_SEQ_IDLE;
               end
            end
            default: begin
               r_state <= TX_SEQ_IDLE;
            end
         endcase
      end
   end

endmodule : uart_tx_sequencer
`default_nettype wire

// File: rtl/uart_mmio_controller.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mmio_controller
//  Purpose  : Memory-mapped register front end for a UART transmitter/receiver
//             pair: TX holding register with start/busy sequencing, RX buffer
//             with sticky frame-error/overrun flags, one level interrupt.
//  Ports    : clk, reset                  - clock, async active-high reset
//             cpu_addr/wr_en/rd_en        - register select and strobes
//             cpu_data_in/cpu_data_out    - write data / combinational read
//             irq                         - registered interrupt level
//             tx_parallel_data_in,
//             tx_strobe_start,
//             tx_strobe_busy              - transmitter handshake
//             rx_strobe_data_ready_level,
//             rx_parallel_data_out,
//             rx_status_reg               - receiver outputs
//  Revision : 1.0 - initial release
// ============================================================================
module uart_mmio_controller
   import arch_defs_pkg::*;
#(
   parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            cpu_addr,
   input  logic                  cpu_wr_en,
   input  logic                  cpu_rd_en,
   input  logic [DATA_WIDTH-1:0] cpu_data_in,
   output logic [DATA_WIDTH-1:0] cpu_data_out,
   output logic                  irq,
   output logic [DATA_WIDTH-1:0] tx_parallel_data_in,
   output logic                  tx_strobe_start,
   input  logic                  tx_strobe_busy,
   input  logic                  rx_strobe_data_ready_level,
   input  logic [DATA_WIDTH-1:0] rx_parallel_data_out,
   input  logic [1:0]            rx_status_reg
);

   logic [DATA_WIDTH-1:0] r_rx_buf;
   logic                  r_rx_full;
   logic                  r_frame_err;
   logic                  r_rx_ovr;
   logic                  r_tx_ovr;
   logic                  r_rx_irq_en;
   logic                  r_tx_irq_en;
   logic                  r_rdy_prev;
   logic                  r_irq;

   logic                  w_data_wr;
   logic                  w_data_rd;
   logic                  w_ctrl_wr;
   logic                  w_cmd_wr;
   logic                  w_clr_err;
   logic                  w_flush;
   logic                  w_capture;
   logic                  w_rx_load;
   logic                  w_rx_overrun;
   logic                  w_hold_full;
   logic                  w_wr_drop;
   logic                  w_fsm_idle;
   logic                  w_unused_rx_status;

   assign w_data_wr    = cpu_wr_en & (cpu_addr == UART_REG_DATA);
   assign w_data_rd    = cpu_rd_en & (cpu_addr == UART_REG_DATA);
   assign w_ctrl_wr    = cpu_wr_en & (cpu_addr == UART_REG_CONTROL);
   assign w_cmd_wr     = cpu_wr_en & (cpu_addr == UART_REG_COMMAND);
   assign w_clr_err    = w_cmd_wr & cpu_data_in[UART_CMD_CLR_ERR];
   assign w_flush      = w_cmd_wr & cpu_data_in[UART_CMD_FLUSH];

   // Rising edge of the receiver ready level marks a new byte. A DATA read in
   // the same cycle frees the buffer, so the new byte is still taken.
   assign w_capture    = rx_strobe_data_ready_level & ~r_rdy_prev;
   assign w_rx_load    = w_capture & (~r_rx_full | w_data_rd);
   assign w_rx_overrun = w_capture & r_rx_full & ~w_data_rd;

   // Only the frame-error bit of the receiver status is meaningful here.
   assign w_unused_rx_status = rx_status_reg[1];

   uart_tx_sequencer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tx_seq (
      .clk                 (clk),
      .reset               (reset),
      .wr_en               (w_data_wr),
      .wr_data             (cpu_data_in),
      .flush               (w_flush),
      .tx_strobe_busy      (tx_strobe_busy),
      .tx_hold_full        (w_hold_full),
      .wr_drop             (w_wr_drop),
      .fsm_idle            (w_fsm_idle),
      .tx_parallel_data_in (tx_parallel_data_in),
      .tx_strobe_start     (tx_strobe_start)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_buf    <= '0;
         r_rx_full   <= 1'b0;
         r_frame_err <= 1'b0;
         r_rx_ovr    <= 1'b0;
         r_tx_ovr    <= 1'b0;
         r_rx_irq_en <= 1'b0;
         r_tx_irq_en <= 1'b0;
         r_rdy_prev  <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_rdy_prev <= rx_strobe_data_ready_level;

         // A capture keeps rx_full set even when a flush or read coincides.
         if (w_rx_load) begin
            r_rx_buf  <= rx_parallel_data_out;
            r_rx_full <= 1'b1;
         end else if (!w_capture && (w_data_rd || w_flush)) begin
            r_rx_full <= 1'b0;
         end

         // Sticky flags: a set event outranks a simultaneous clear.
         if (w_capture && rx_status_reg[0]) begin
            r_frame_err <= 1'b1;
         end else if (w_clr_err) begin
            r_frame_err <= 1'b0;
         end

         if (w_rx_overrun) begin
            r_rx_ovr <= 1'b1;
         end else if (w_clr_err) begin
            r_rx_ovr <= 1'b0;
         end

         if (w_wr_drop) begin
            r_tx_ovr <= 1'b1;
         end else if (w_clr_err) begin
            r_tx_ovr <= 1'b0;
         end

         if (w_ctrl_wr) begin
            r_rx_irq_en <= cpu_data_in[UART_CTRL_RX_IRQ_EN];
            r_tx_irq_en <= cpu_data_in[UART_CTRL_TX_IRQ_EN];
         end

         r_irq <= (r_rx_irq_en & r_rx_full) |
                  (r_tx_irq_en & ~w_hold_full & w_fsm_idle);
      end
   end

   assign irq = r_irq;

   always_comb begin
      cpu_data_out = '0;
      case (cpu_addr)
         UART_REG_DATA: begin
            cpu_data_out = r_rx_buf;
         end
         UART_REG_STATUS: begin
            cpu_data_out[UART_STAT_TX_EMPTY]  = ~w_hold_full;
            cpu_data_out[UART_STAT_RX_FULL]   = r_rx_full;
            cpu_data_out[UART_STAT_FRAME_ERR] = r_frame_err;
            cpu_data_out[UART_STAT_RX_OVR]    = r_rx_ovr;
            cpu_data_out[UART_STAT_TX_OVR]    = r_tx_ovr;
         end
         UART_REG_CONTROL: begin
            cpu_data_out[UART_CTRL_RX_IRQ_EN] = r_rx_irq_en;
            cpu_data_out[UART_CTRL_TX_IRQ_EN] = r_tx_irq_en;
         end
         default: begin
            cpu_data_out = '0;
         end
      endcase
   end

endmodule : uart_mmio_controller
`default_nettype wire

// File: tb/tb_uart_mmio_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_mmio_controller
//  Purpose  : Directed self-checking bench for uart_mmio_controller. The
//             transmitter busy level and receiver outputs are driven directly.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mmio_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] cpu_addr = 2'd0;
   logic       cpu_wr_en = 1'b0;
   logic       cpu_rd_en = 1'b0;
   logic [7:0] cpu_data_in = 8'h00;
   logic [7:0] cpu_data_out;
   logic       irq;
   logic [7:0] tx_parallel_data_in;
   logic       tx_strobe_start;
   logic       tx_strobe_busy = 1'b0;
   logic       rx_rdy = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [1:0] rx_status = 2'b00;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [1:0] A_DATA = 2'd0;
   localparam logic [1:0] A_STAT = 2'd1;
   localparam logic [1:0] A_CTRL = 2'd2;
   localparam logic [1:0] A_CMD  = 2'd3;

   uart_mmio_controller #(.DATA_WIDTH(8)) dut (
      .clk                        (clk),
      .reset                      (reset),
      .cpu_addr                   (cpu_addr),
      .cpu_wr_en                  (cpu_wr_en),
      .cpu_rd_en                  (cpu_rd_en),
      .cpu_data_in                (cpu_data_in),
      .cpu_data_out               (cpu_data_out),
      .irq                        (irq),
      .tx_parallel_data_in        (tx_parallel_data_in),
      .tx_strobe_start            (tx_strobe_start),
      .tx_strobe_busy             (tx_strobe_busy),
      .rx_strobe_data_ready_level (rx_rdy),
      .rx_parallel_data_out       (rx_data),
      .rx_status_reg              (rx_status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      cpu_addr    = a;
      cpu_data_in = d;
      cpu_wr_en   = 1'b1;
      tick();
      cpu_wr_en   = 1'b0;
   endtask

   // Read with side effects: the value is captured before the strobe edge.
   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      cpu_addr  = a;
      cpu_rd_en = 1'b1;
      #1;
      d = cpu_data_out;
      tick();
      cpu_rd_en = 1'b0;
   endtask

   task automatic peek(input logic [1:0] a, output logic [7:0] d);
      cpu_addr = a;
      #1;
      d = cpu_data_out;
   endtask

   initial begin
      logic [7:0] v;

      // ---------------- reset state ----------------
      #2;
      check("rst_irq",   {7'b0, irq}, 8'h00);
      check("rst_start", {7'b0, tx_strobe_start}, 8'h00);
      check("rst_txd",   tx_parallel_data_in, 8'h00);
      check("rst_data",  cpu_data_out, 8'h00);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      tick();
      peek(A_STAT, v); check("rst_status", v, 8'h01);
      peek(A_CTRL, v); check("rst_ctrl", v, 8'h00);

      // ---------------- single transmit ----------------
      wr(A_DATA, 8'hB2);
      check("tx1_no_start_yet", {7'b0, tx_strobe_start}, 8'h00);
      peek(A_STAT, v); check("tx1_hold_full", v, 8'h00);
      tick();
      check("tx1_start", {7'b0, tx_strobe_start}, 8'h01);
      check("tx1_data", tx_parallel_data_in, 8'hB2);
      tick();
      check("tx1_start_one_cycle", {7'b0, tx_strobe_start}, 8'h00);
      peek(A_STAT, v); check("tx1_hold_empty", v, 8'h01);
      tx_strobe_busy = 1'b1; tick();
      tx_strobe_busy = 1'b0; tick();
      check("tx1_data_held", tx_parallel_data_in, 8'hB2);

      // ---------------- back-to-back with overflow ----------------
      wr(A_DATA, 8'h11);
      tick();
      check("b2b_start1", {7'b0, tx_strobe_start}, 8'h01);
      check("b2b_data1", tx_parallel_data_in, 8'h11);
      tick();
      tx_strobe_busy = 1'b1;
      wr(A_DATA, 8'h22);
      wr(A_DATA, 8'h33);
      peek(A_STAT, v); check("b2b_tx_ovr", v, 8'h10);
      check("b2b_data1_held", tx_parallel_data_in, 8'h11);
      tx_strobe_busy = 1'b0;
      tick();
      check("b2b_no_early_start", {7'b0, tx_strobe_start}, 8'h00);
      tick();
      check("b2b_start2", {7'b0, tx_strobe_start}, 8'h01);
      check("b2b_data2", tx_parallel_data_in, 8'h22);
      tick();
      peek(A_STAT, v); check("b2b_after_launch", v, 8'h11);
      tx_strobe_busy = 1'b1; tick();
      tx_strobe_busy = 1'b0; tick();
      check("b2b_no_third", {7'b0, tx_strobe_start}, 8'h00);
      wr(A_CMD, 8'h01);
      peek(A_STAT, v); check("b2b_clr", v, 8'h01);

      // ---------------- RX receive ----------------
      rx_data = 8'hB2; rx_rdy = 1'b1; tick();
      rx_rdy = 1'b0;
      peek(A_STAT, v); check("rx_status_full", v, 8'h03);
      rd(A_DATA, v); check("rx_data", v, 8'hB2);
      peek(A_STAT, v); check("rx_status_read", v, 8'h01);

      // ---------------- frame error ----------------
      rx_data = 8'h5A; rx_status = 2'b01; rx_rdy = 1'b1; tick();
      rx_rdy = 1'b0; rx_status = 2'b00;
      peek(A_STAT, v); check("fe_set", v, 8'h07);
      wr(A_CMD, 8'h01);
      peek(A_STAT, v); check("fe_clr", v, 8'h03);
      rd(A_DATA, v); check("fe_data", v, 8'h5A);

      // ---------------- overrun ----------------
      rx_data = 8'h01; rx_rdy = 1'b1; tick();
      rx_rdy = 1'b0; tick();
      rx_data = 8'h02; rx_rdy = 1'b1; tick();
      rx_rdy = 1'b0;
      peek(A_STAT, v); check("ovr_status", v, 8'h0B);
      rd(A_DATA, v); check("ovr_first_kept", v, 8'h01);
      peek(A_STAT, v); check("ovr_after_read", v, 8'h09);
      wr(A_CMD, 8'h01);

      // read in the same cycle as a capture: new byte accepted, no overrun
      rx_data = 8'h03; rx_rdy = 1'b1; tick();
      rx_rdy = 1'b0; tick();
      rx_data = 8'h04; rx_rdy = 1'b1;
      rd(A_DATA, v); check("same_cyc_old", v, 8'h03);
      rx_rdy = 1'b0;
      peek(A_STAT, v); check("same_cyc_status", v, 8'h03);
      rd(A_DATA, v); check("same_cyc_new", v, 8'h04);

      // flush with simultaneous capture: capture wins
      rx_data = 8'h77; rx_rdy = 1'b1;
      wr(A_CMD, 8'h02);
      rx_rdy = 1'b0;
      peek(A_STAT, v); check("flush_vs_cap", v, 8'h03);
      wr(A_CMD, 8'h02);
      peek(A_STAT, v); check("flush_alone", v, 8'h01);

      // clear with simultaneous overrun: set wins
      rx_data = 8'h88; rx_rdy = 1'b1; tick();
      rx_rdy = 1'b0; tick();
      rx_rdy = 1'b1;
      wr(A_CMD, 8'h01);
      rx_rdy = 1'b0;
      peek(A_STAT, v); check("set_wins", v, 8'h0B);
      wr(A_CMD, 8'h03);
      peek(A_STAT, v); check("clr_flush", v, 8'h01);

      // ---------------- interrupts ----------------
      wr(A_CTRL, 8'h01);
      peek(A_CTRL, v); check("ctrl_rb1", v, 8'h01);
      check("irq_off", {7'b0, irq}, 8'h00);
      rx_data = 8'h9C; rx_rdy = 1'b1; tick();
      rx_rdy = 1'b0;
      check("irq_lag", {7'b0, irq}, 8'h00);
      tick();
      check("irq_rx", {7'b0, irq}, 8'h01);
      rd(A_DATA, v); check("irq_data", v, 8'h9C);
      check("irq_hold", {7'b0, irq}, 8'h01);
      tick();
      check("irq_drop", {7'b0, irq}, 8'h00);
      wr(A_CTRL, 8'hFE);
      tick();
      check("irq_tx", {7'b0, irq}, 8'h01);
      peek(A_CTRL, v); check("ctrl_rb2", v, 8'h02);
      peek(A_CMD, v);  check("cmd_reads0", v, 8'h00);

      // ---------------- async reset during WAIT_DONE ----------------
      wr(A_DATA, 8'h3C);
      tick(); tick();
      tx_strobe_busy = 1'b1; tick();
      check("mid_txd", tx_parallel_data_in, 8'h3C);
      #2;
      reset = 1'b1;
      cpu_addr = A_DATA;
      #1;
      check("mr_irq",   {7'b0, irq}, 8'h00);
      check("mr_start", {7'b0, tx_strobe_start}, 8'h00);
      check("mr_txd",   tx_parallel_data_in, 8'h00);
      check("mr_data",  cpu_data_out, 8'h00);
      peek(A_STAT, v); check("mr_status", v, 8'h01);
      tx_strobe_busy = 1'b0;
      #1;
      reset = 1'b0;
      tick(); tick();
      check("post_rst_no_start", {7'b0, tx_strobe_start}, 8'h00);
      check("post_rst_irq", {7'b0, irq}, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_uart_mmio_controller
`default_nettype wire
